fib_seq_checker: RTL and testbench
==================================

Name: fib_seq_checker

Overview:
- Parametrised, sequential successor to the 4-bit combinational Fibonacci recogniser.
- Accepts one WIDTH-bit unsigned value over a valid/ready handshake and generates the Fibonacci sequence iteratively, F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
- Reports whether the value is a Fibonacci number, its index, and a running hit count.
- Sits between an input source (switches or upstream logic) and display/consumer logic with back-pressure.

Parameters:
WIDTH, 16, width of the input value (unsigned); legal range 4..32
IDX_W, 7, width of fib_index; must satisfy 2^IDX_W > 1.5*WIDTH+4
CNT_W, 8, width of the saturating hit counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  value is presented
in_ready  out  1  block can accept a value
value  in  WIDTH  unsigned value to classify
out_valid  out  1  result is valid; held until consumed
out_ready  in  1  consumer accepts the result
is_fib  out  1  1 if value is a Fibonacci number
fib_index  out  IDX_W  smallest k with F(k)=value; 0 when is_fib=0
hit_count  out  CNT_W  number of results with is_fib=1, saturating
busy  out  1  high in ITER or DONE

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (reset).
- While reset is asserted, all registers clear immediately:
  - state=IDLE
  - out_valid=0, is_fib=0, fib_index=0, hit_count=0, busy=0
  - internal target, a, b and idx=0
  - in_ready=0 while reset is high; in_ready=1 from the first cycle after deassertion.
- FSM states: IDLE, ITER, DONE.
- in_ready = (state==IDLE) & ~reset. in_valid is ignored outside IDLE, and there is no queuing.
- IDLE: on a rising edge with in_valid & in_ready:
  - target <= value, a <= 0, b <= 1, idx <= 0
  - go to ITER.
- ITER: every cycle compares a (=F(idx)) against target.
  - a == target: is_fib <= 1, fib_index <= idx, go to DONE.
  - a > target: is_fib <= 0, fib_index <= 0, go to DONE.
  - otherwise: a <= b, b <= a+b, idx <= idx+1; stay in ITER.
- a and b are WIDTH+2 bits wide, so no overflow can occur before a > target. The comparison is an unsigned compare at WIDTH+2 bits.
- Entering DONE: out_valid <= 1. hit_count increments if the result is a hit; it saturates at 2^CNT_W-1 and is cleared only by reset.
- DONE:
  - outputs (is_fib, fib_index, out_valid) hold stable until out_ready is high at a rising edge.
  - on that edge: out_valid <= 0, go to IDLE.
  - a new value can be accepted at the earliest on the following edge.
- Latency: let k be the decision index (the first k with F(k) >= value).
  - out_valid rises k+1 cycles after the accepting edge.
  - value 0: 1 cycle; value 1: 2 cycles (index 1, never 2).
- The first match wins: value 1 reports index 1.
- is_fib and fib_index are registered. They retain their last result in IDLE and ITER and are only meaningful while out_valid=1.
- Reset asserted mid-ITER or mid-DONE: the operation is aborted, no result is produced, and hit_count is cleared.
- in_valid held high across a result: exactly one new accept happens after returning to IDLE. There is no double accept.

Test Plan:
- Reset, then value=0 with in_valid → accepted on the first edge; out_valid after 1 cycle; is_fib=1, fib_index=0, hit_count=1.
- value=13 → out_valid after 8 cycles, is_fib=1, fib_index=7. Then value=14 → out_valid after 9 cycles, is_fib=0, fib_index=0, hit_count unchanged.
- Sweep 0..15 with out_ready=1:
  - is_fib=1 exactly for {0,1,2,3,5,8,13}, matching the 4-bit recogniser truth table.
  - value 1 reports index 1.
- Boundary:
  - value=46368 → is_fib=1, fib_index=24, latency 25.
  - value=16'hFFFF → is_fib=0, latency 26, with no overflow corruption.
- Back-pressure: out_ready low for 5 cycles after out_valid → is_fib, fib_index and out_valid stay stable, in_ready=0. Raise out_ready → IDLE next edge, in_ready=1.
- Reset pulse during ITER on value=46368 → outputs and hit_count go to 0 immediately. No out_valid follows. Next value=5 → is_fib=1, fib_index=5, hit_count=1.

Source files
------------

// File: rtl/fib_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : fib_seq_checker
// Purpose  : Sequential Fibonacci recogniser. It accepts one WIDTH-bit
//            unsigned value over a valid/ready handshake. It walks the
//            Fibonacci sequence F(0)=0, F(1)=1, ... one term per cycle and
//            reports whether the value is a Fibonacci number and, if so, its
//            smallest index. It also keeps a saturating count of hits.
// Ports    : clk_i        - system clock, rising edge
//            reset_i      - asynchronous, active-high reset
//            in_valid_i   - a value is presented on value_i
//            in_ready_o   - a value can be accepted (IDLE, not in reset)
//            value_i      - unsigned value to classify
//            out_valid_o  - result valid; held until out_ready_i
//            out_ready_i  - consumer takes the result
//            is_fib_o     - value is a Fibonacci number
//            fib_index_o  - smallest k with F(k)=value, 0 when not a hit
//            hit_count_o  - number of hits, saturating, cleared by reset
//            busy_o       - high while iterating or holding a result
// Revision : 1.0 - initial release
// ============================================================================
module fib_seq_checker #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] value_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             is_fib_o,
  output logic [IDX_W-1:0] fib_index_o,
  output logic [CNT_W-1:0] hit_count_o,
  output logic             busy_o
);

  // Two guard bits let the sequence overshoot any WIDTH-bit target without
  // wrapping: the first term above 2^WIDTH-1 and its successor both fit.
  localparam int AW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [AW-1:0]    a_q, a_d;
  logic [AW-1:0]    b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             is_fib_q, is_fib_d;
  logic [IDX_W-1:0] fib_index_q, fib_index_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;

  logic [AW-1:0]    target_ext;

  assign target_ext  = {2'b00, target_q};
  assign in_ready_o  = (state_q == IDLE) & ~reset_i;
  assign busy_o      = (state_q == ITER) | (state_q == DONE);
  assign out_valid_o = out_valid_q;
  assign is_fib_o    = is_fib_q;
  assign fib_index_o = fib_index_q;
  assign hit_count_o = hit_count_q;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    is_fib_d    = is_fib_q;
    fib_index_d = fib_index_q;
    out_valid_d = out_valid_q;
    hit_count_d = hit_count_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          target_d = value_i;
          a_d      = '0;
          b_d      = AW'(1);
          idx_d    = '0;
          state_d  = ITER;
        end
      end

      ITER: begin
        // a always holds F(idx). Test equality first so that the lowest
        // matching index wins (value 1 reports index 1).
        if (a_q == target_ext) begin
          is_fib_d    = 1'b1;
          fib_index_d = idx_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
          if (hit_count_q != {CNT_W{1'b1}}) begin
            hit_count_d = hit_count_q + CNT_W'(1);
          end
        end else if (a_q > target_ext) begin
          is_fib_d    = 1'b0;
          fib_index_d = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          a_d   = b_q;
          b_d   = a_q + b_q;
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      target_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      is_fib_q    <= 1'b0;
      fib_index_q <= '0;
      out_valid_q <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      is_fib_q    <= is_fib_d;
      fib_index_q <= fib_index_d;
      out_valid_q <= out_valid_d;
      hit_count_q <= hit_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_seq_checker
// Purpose  : Directed self-checking bench for fib_seq_checker with default
//            parameters (WIDTH=16, IDX_W=7, CNT_W=8). Expected values are
//            hand-computed from the Fibonacci sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_seq_checker;

  localparam int WIDTH = 16;
  localparam int IDX_W = 7;
  localparam int CNT_W = 8;

  logic             clk_i;
  logic             reset_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] value_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             is_fib_o;
  logic [IDX_W-1:0] fib_index_o;
  logic [CNT_W-1:0] hit_count_o;
  logic             busy_o;

  int n_asserts = 0;
  int n_fail    = 0;

  // Hand-computed results for values 0..15.
  // Fibonacci terms: 0 1 1 2 3 5 8 13 21
  // lat = (first k with F(k) >= v) + 1
  logic        sw_fib [16] = '{1,1,1,1,0,1,0,0,1,0,0,0,0,1,0,0};
  int          sw_idx [16] = '{0,1,3,4,0,5,0,0,6,0,0,0,0,7,0,0};
  int          sw_lat [16] = '{1,2,4,5,6,6,7,7,7,8,8,8,8,8,9,9};

  fib_seq_checker #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .value_i     (value_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .is_fib_o    (is_fib_o),
    .fib_index_o (fib_index_o),
    .hit_count_o (hit_count_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present v, wait for the result, check latency and result fields.
  // With ack=1 the result is consumed on the edge after it appears.
  task automatic run(input string tag, input logic [WIDTH-1:0] v, input bit ack,
                     input logic exp_f, input int exp_idx, input int exp_lat,
                     input int exp_hits);
    int n;
    value_i     = v;
    in_valid_i  = 1'b1;
    out_ready_i = ack;
    chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({tag, "_latency"},   n,                   exp_lat);
    chk({tag, "_is_fib"},    32'(is_fib_o),       32'(exp_f));
    chk({tag, "_fib_index"}, 32'(fib_index_o),    exp_idx);
    chk({tag, "_hit_count"}, 32'(hit_count_o),    exp_hits);
    if (ack) begin
      @(posedge clk_i); #1;
      chk({tag, "_consumed"}, {30'd0, out_valid_o, in_ready_o}, 32'b01);
    end
  endtask

  initial begin
    int n;
    reset_i     = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    value_i     = '0;
    #1;
    chk("rst_in_ready",  32'(in_ready_o),  32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_is_fib",    32'(is_fib_o),    32'd0);
    chk("rst_fib_index", 32'(fib_index_o), 32'd0);
    chk("rst_hit_count", 32'(hit_count_o), 32'd0);
    chk("rst_busy",      32'(busy_o),      32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;

    // Basic results
    run("v0",  16'd0,  1'b1, 1'b1, 0, 1, 1);
    run("v13", 16'd13, 1'b1, 1'b1, 7, 8, 2);
    run("v14", 16'd14, 1'b1, 1'b0, 0, 9, 2);

    // Sweep the 4-bit range: hits are {0,1,2,3,5,8,13}
    n = 2;
    for (int v = 0; v < 16; v++) begin
      if (sw_fib[v]) n++;
      run($sformatf("sw%0d", v), 16'(v), 1'b1, sw_fib[v], sw_idx[v], sw_lat[v], n);
    end

    // Top-of-range boundaries
    run("v46368", 16'd46368, 1'b1, 1'b1, 24, 25, 10);
    run("vFFFF",  16'hFFFF,  1'b1, 1'b0, 0,  26, 10);

    // Back-pressure on 21 = F(8), with a new value waiting during DONE
    run("bp21", 16'd21, 1'b0, 1'b1, 8, 9, 11);
    value_i    = 16'd3;
    in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("bp_hold", {29'd0, out_valid_o, is_fib_o, in_ready_o}, 32'b110);
      chk("bp_hold_idx", 32'(fib_index_o), 32'd8);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("bp_release", {29'd0, out_valid_o, in_ready_o, busy_o}, 32'b010);
    @(posedge clk_i); #1;
    chk("bp_accept_once", {30'd0, in_ready_o, busy_o}, 32'b01);
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("bp3_latency",   n,                   5);
    chk("bp3_is_fib",    32'(is_fib_o),       32'd1);
    chk("bp3_fib_index", 32'(fib_index_o),    32'd4);
    chk("bp3_hit_count", 32'(hit_count_o),    32'd12);
    @(posedge clk_i); #1;
    chk("bp3_consumed", {30'd0, out_valid_o, in_ready_o}, 32'b01);

    // Reset abort in the middle of the iteration
    value_i    = 16'd46368;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    chk("abort_busy_before", 32'(busy_o), 32'd1);
    reset_i = 1'b1;
    #1;
    chk("abort_outputs", {28'd0, out_valid_o, is_fib_o, in_ready_o, busy_o}, 32'd0);
    chk("abort_hit_count", 32'(hit_count_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i); #1;
      if (out_valid_o) n++;
    end
    chk("abort_no_result", n, 0);
    run("post5", 16'd5, 1'b1, 1'b1, 5, 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
